// File: rtl/vid_pkg.sv
// Shared video constants, pixel payload types, luma helper and frame-FSM encoding.
package vid_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned PIX_W        = 8;
  localparam int unsigned COORD_W      = 13;

  localparam int unsigned LUMA_R = 77;
  localparam int unsigned LUMA_G = 150;
  localparam int unsigned LUMA_B = 29;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } frame_state_e;

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } rgb_t;

  // Per-pixel side information carried alongside the data path.
  typedef struct packed {
    logic               ok;
    logic               en;
    logic               gate;
    rgb_t               rgb;
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
  } pix_meta_t;

  // Coefficients sum to 256, so the 16-bit accumulator never overflows.
  function automatic logic [PIX_W-1:0] luma(input rgb_t p);
    logic [15:0] acc;
    acc = 16'(LUMA_R * 32'(p.r)) + 16'(LUMA_G * 32'(p.g)) + 16'(LUMA_B * 32'(p.b));
    return PIX_W'(acc >> 8);
  endfunction

endpackage

// File: rtl/line_buffer.sv
// Single-port line store with registered read; a same-address write returns the old word.
module line_buffer #(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // No reset on the array or read register so the store maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sobel_edge_filter.sv
// 3x3 Sobel edge detector on camera luma with pixel-aligned passthrough mode.
module sobel_edge_filter
  import vid_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PIX_W-1:0]   i_VGA_R,
  input  logic [PIX_W-1:0]   i_VGA_G,
  input  logic [PIX_W-1:0]   i_VGA_B,
  input  logic [COORD_W-1:0] row,
  input  logic [COORD_W-1:0] col,
  input  logic               pix_valid,
  input  logic               edge_enable,
  input  logic [PIX_W-1:0]   threshold,
  output logic [PIX_W-1:0]   o_VGA_R,
  output logic [PIX_W-1:0]   o_VGA_G,
  output logic [PIX_W-1:0]   o_VGA_B,
  output logic [COORD_W-1:0] o_row,
  output logic [COORD_W-1:0] o_col,
  output logic               o_valid
);

  localparam int unsigned LATENCY     = 4;
  localparam int unsigned META_STAGES = LATENCY - 1;
  localparam int unsigned AW          = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;

  frame_state_e state_q, state_d;

  logic      in_ok;
  logic      sof;
  pix_meta_t in_meta;

  pix_meta_t [META_STAGES-1:0] meta_q, meta_d;

  logic [PIX_W-1:0] y1_q, y1_d;
  logic [PIX_W-1:0] y2_q, y2_d;
  logic [PIX_W-1:0] m2_q, m2_d;
  logic [PIX_W-1:0] rd0, rd1;

  logic [2:0][2:0][PIX_W-1:0] win_q, win_d;

  logic [10:0]        sum_r, sum_l, sum_b, sum_t;
  logic signed [10:0] gx_c, gy_c;
  logic [10:0]        gx_abs, gy_abs;
  logic [11:0]        mag_c;
  logic [PIX_W-1:0]   mag_sat;
  logic [PIX_W-1:0]   edge_px;

  rgb_t               out_q, out_d;
  logic [COORD_W-1:0] o_row_q, o_row_d;
  logic [COORD_W-1:0] o_col_q, o_col_d;
  logic               o_valid_q, o_valid_d;

  assign in_ok = pix_valid && (32'(row) < V_ACTIVE) && (32'(col) < H_ACTIVE);
  assign sof   = in_ok && (row == '0) && (col == '0);

  // Frame tracking: any SOF restarts the fill phase.
  always_comb begin
    state_d = state_q;
    if (sof) begin
      state_d = ST_FILL;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_FILL: if (in_ok && (row == COORD_W'(2))) state_d = ST_RUN;
        ST_RUN:  state_d = ST_RUN;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Side-band pipeline and luma / line-buffer alignment registers.
  always_comb begin
    in_meta = '{ok:   in_ok,
                en:   edge_enable,
                gate: (state_d == ST_RUN) && (col >= COORD_W'(2)),
                rgb:  '{r: i_VGA_R, g: i_VGA_G, b: i_VGA_B},
                row:  row,
                col:  col};
    meta_d[0] = in_meta;
    for (int i = 1; i < META_STAGES; i++) meta_d[i] = meta_q[i-1];
    y1_d = luma(in_meta.rgb);
    y2_d = y1_q;
    m2_d = rd0;
  end

  // lb0 holds the previous line; lb1 is fed from lb0's output one cycle later.
  line_buffer #(.DEPTH(H_ACTIVE), .WIDTH(PIX_W), .AW(AW)) u_lb0 (
    .clk   (clk),
    .we    (in_ok),
    .addr  (AW'(col)),
    .wdata (y1_d),
    .rdata (rd0)
  );

  line_buffer #(.DEPTH(H_ACTIVE), .WIDTH(PIX_W), .AW(AW)) u_lb1 (
    .clk   (clk),
    .we    (meta_q[0].ok),
    .addr  (AW'(meta_q[0].col)),
    .wdata (rd0),
    .rdata (rd1)
  );

  // Window index [row][col]: row 0 is oldest line, col 2 is newest column.
  always_comb begin
    win_d = win_q;
    if (meta_q[1].ok) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = (meta_q[1].col == '0) ? '0 : win_q[r][1];
        win_d[r][1] = (meta_q[1].col == '0) ? '0 : win_q[r][2];
      end
      win_d[0][2] = rd1;
      win_d[1][2] = m2_q;
      win_d[2][2] = y2_q;
    end
  end

  always_comb begin
    sum_r   = 11'(win_q[0][2]) + 11'({win_q[1][2], 1'b0}) + 11'(win_q[2][2]);
    sum_l   = 11'(win_q[0][0]) + 11'({win_q[1][0], 1'b0}) + 11'(win_q[2][0]);
    sum_b   = 11'(win_q[2][0]) + 11'({win_q[2][1], 1'b0}) + 11'(win_q[2][2]);
    sum_t   = 11'(win_q[0][0]) + 11'({win_q[0][1], 1'b0}) + 11'(win_q[0][2]);
    gx_c    = $signed(sum_r - sum_l);
    gy_c    = $signed(sum_b - sum_t);
    gx_abs  = gx_c[10] ? 11'(-gx_c) : 11'(gx_c);
    gy_abs  = gy_c[10] ? 11'(-gy_c) : 11'(gy_c);
    mag_c   = 12'(gx_abs) + 12'(gy_abs);
    mag_sat = (mag_c > 12'd255) ? 8'hFF : mag_c[7:0];
    edge_px = (meta_q[2].gate && meta_q[2].ok && (mag_sat > threshold)) ? 8'hFF : 8'h00;
  end

  always_comb begin
    out_d     = meta_q[2].en ? '{r: edge_px, g: edge_px, b: edge_px} : meta_q[2].rgb;
    o_row_d   = meta_q[2].row;
    o_col_d   = meta_q[2].col;
    o_valid_d = meta_q[2].ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      meta_q    <= '0;
      y1_q      <= '0;
      y2_q      <= '0;
      m2_q      <= '0;
      win_q     <= '0;
      out_q     <= '0;
      o_row_q   <= '0;
      o_col_q   <= '0;
      o_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      meta_q    <= meta_d;
      y1_q      <= y1_d;
      y2_q      <= y2_d;
      m2_q      <= m2_d;
      win_q     <= win_d;
      out_q     <= out_d;
      o_row_q   <= o_row_d;
      o_col_q   <= o_col_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign o_VGA_R = out_q.r;
  assign o_VGA_G = out_q.g;
  assign o_VGA_B = out_q.b;
  assign o_row   = o_row_q;
  assign o_col   = o_col_q;
  assign o_valid = o_valid_q;

endmodule

// File: tb/tb_sobel_edge_filter.sv
// Randomized frame-level bench for sobel_edge_filter against an image-space Sobel model.
module tb_sobel_edge_filter;

  localparam int H = 24;
  localparam int V = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  i_r, i_g, i_b, thr;
  logic [12:0] row, col;
  logic        pix_valid, edge_enable;
  logic [7:0]  o_r, o_g, o_b;
  logic [12:0] o_row, o_col;
  logic        o_valid;

  sobel_edge_filter #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_VGA_R     (i_r),
    .i_VGA_G     (i_g),
    .i_VGA_B     (i_b),
    .row         (row),
    .col         (col),
    .pix_valid   (pix_valid),
    .edge_enable (edge_enable),
    .threshold   (thr),
    .o_VGA_R     (o_r),
    .o_VGA_G     (o_g),
    .o_VGA_B     (o_b),
    .o_row       (o_row),
    .o_col       (o_col),
    .o_valid     (o_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit valid;
    int row;
    int col;
    int rgb;
  } exp_t;

  exp_t exp_q[$];
  int   img [V][H];
  bit   live;
  int   total = 0;
  int   bad = 0;
  int   ff_cnt = 0;

  task automatic check(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int luma_m(input int r, input int g, input int b);
    return (77 * r + 150 * g + 29 * b) / 256;
  endfunction

  // Edge decision for the window whose newest pixel is (r,c), centred at (r-1,c-1).
  function automatic int edge_m(input int r, input int c, input int t);
    int gx, gy, m;
    if (!live || r < 2 || c < 2) return 0;
    gx = (img[r-2][c] + 2 * img[r-1][c] + img[r][c])
       - (img[r-2][c-2] + 2 * img[r-1][c-2] + img[r][c-2]);
    gy = (img[r][c-2] + 2 * img[r][c-1] + img[r][c])
       - (img[r-2][c-2] + 2 * img[r-2][c-1] + img[r-2][c]);
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (m > 255) m = 255;
    return (m > t) ? 255 : 0;
  endfunction

  task automatic push_zero();
    exp_t e;
    e = '{valid: 1'b0, row: 0, col: 0, rgb: 0};
    exp_q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() >= 4) begin
      e = exp_q.pop_front();
      check("o_valid", int'(o_valid), int'(e.valid));
      check("o_row", int'(o_row), e.row);
      check("o_col", int'(o_col), e.col);
      if (e.valid) begin
        check("pixel", int'({o_r, o_g, o_b}), e.rgb);
        if (o_r == 8'hFF) ff_cnt++;
      end
    end
  endtask

  task automatic drive(input int r, input int c, input bit v, input int pr, input int pg,
                       input int pb, input bit en, input int t);
    exp_t e;
    bit   ok;
    int   px;
    row = 13'(r); col = 13'(c); pix_valid = v;
    i_r = 8'(pr); i_g = 8'(pg); i_b = 8'(pb);
    edge_enable = en; thr = 8'(t);
    ok = v && (r < V) && (c < H);
    if (ok) begin
      if (r == 0 && c == 0) live = 1'b1;
      img[r][c] = luma_m(pr, pg, pb);
    end
    if (en) px = ok ? edge_m(r, c, t) * 65793 : 0;
    else    px = (pr << 16) | (pg << 8) | pb;
    e = '{valid: ok, row: r, col: c, rgb: px};
    exp_q.push_back(e);
    tick();
  endtask

  task automatic flush(input bit en, input int t);
    repeat (4) drive(0, 0, 1'b0, 0, 0, 0, en, t);
  endtask

  // mode: 0 flat grey, 1 vertical step at H/2, 2 random; en_mode 2 = per-pixel random.
  task automatic frame(input int mode, input int t, input int en_mode, input int r0, input int r1);
    int pr, pg, pb;
    bit en;
    for (int r = r0; r <= r1; r++) begin
      for (int c = 0; c < H + 3; c++) begin
        en = (en_mode == 2) ? bit'($urandom_range(0, 1)) : bit'(en_mode);
        if ($urandom_range(0, 3) == 0)
          drive($urandom_range(0, 8191), $urandom_range(0, 8191), 1'b0,
                $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), en, t);
        case (mode)
          0:       begin pr = 8'h80; pg = 8'h80; pb = 8'h80; end
          1:       begin pr = (c < H / 2) ? 0 : 255; pg = pr; pb = pr; end
          default: begin
            pr = $urandom_range(0, 255); pg = $urandom_range(0, 255); pb = $urandom_range(0, 255);
          end
        endcase
        drive(r, c, 1'b1, pr, pg, pb, en, t);
      end
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst o_valid", int'(o_valid), 0);
    check("rst o_row", int'(o_row), 0);
    check("rst o_col", int'(o_col), 0);
    check("rst pixel", int'({o_r, o_g, o_b}), 0);
    exp_q.delete();
    live = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (3) push_zero();
  endtask

  initial begin
    int t;
    i_r = 0; i_g = 0; i_b = 0; thr = 0; row = 0; col = 0;
    pix_valid = 0; edge_enable = 0;
    live = 1'b0;
    for (int r = 0; r < V; r++) for (int c = 0; c < H; c++) img[r][c] = 0;
    do_reset();

    drive(3, 5, 1'b1, 8'h12, 8'h34, 8'h56, 1'b0, 0);
    flush(1'b0, 0);

    frame(2, $urandom_range(0, 255), 0, 0, V - 1);
    flush(1'b0, 0);

    ff_cnt = 0;
    frame(0, 8'h10, 1, 0, V - 1);
    flush(1'b1, 8'h10);
    check("flat ff count", ff_cnt, 0);

    ff_cnt = 0;
    frame(1, 8'h40, 1, 0, V - 1);
    flush(1'b1, 8'h40);
    check("step ff count", ff_cnt, 2 * (V - 2));

    ff_cnt = 0;
    frame(1, 8'hFF, 1, 0, V - 1);
    flush(1'b1, 8'hFF);
    check("step thr255 ff count", ff_cnt, 0);

    ff_cnt = 0;
    frame(1, 8'hFE, 1, 0, V - 1);
    flush(1'b1, 8'hFE);
    check("step thr254 ff count", ff_cnt, 2 * (V - 2));

    t = $urandom_range(20, 200);
    frame(2, t, 1, 0, V - 1);
    flush(1'b1, t);

    t = $urandom_range(20, 200);
    frame(2, t, 2, 0, V - 1);
    flush(1'b1, t);

    frame(2, 8'h20, 1, 0, 5);
    ff_cnt = 0;
    frame(1, 8'h40, 1, 0, V - 1);
    flush(1'b1, 8'h40);
    check("restart ff count", ff_cnt, 2 * (V - 2));

    t = $urandom_range(10, 100);
    frame(2, t, 1, 0, 4);
    do_reset();
    frame(2, t, 1, 5, V - 1);
    flush(1'b1, t);
    frame(2, t, 1, 0, V - 1);
    flush(1'b1, t);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
    $fatal(1);
  end

endmodule

// File: doc/sobel_edge_filter.md
SOBEL_EDGE_FILTER -- requirements
Module: sobel_edge_filter

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, active lines per frame.
REQ-003 SHALL have parameter LATENCY, fixed 4, input-to-output delay in cycles (not overridable).
REQ-004 SHALL have port clk  in  1  pixel clock; all logic rising-edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_VGA_R, i_VGA_G, i_VGA_B  in  8 each  processed camera pixel from the colour/intensity stage.
REQ-007 SHALL have ports row, col  in  13 each  pixel coordinate aligned with i_VGA_*.
REQ-008 SHALL have port pix_valid  in  1  pixel qualifier; high for active pixels only.
REQ-009 SHALL have port edge_enable  in  1  1 = Sobel output, 0 = delayed passthrough.
REQ-010 SHALL have port threshold  in  8  edge decision level.
REQ-011 SHALL have ports o_VGA_R, o_VGA_G, o_VGA_B  out  8 each  result pixel.
REQ-012 SHALL have ports o_row, o_col  out  13 each  input coordinates delayed by LATENCY.
REQ-013 SHALL have port o_valid  out  1  pix_valid delayed by LATENCY.

Function
REQ-014 SHALL treat a pixel with pix_valid=1 and row>=V_ACTIVE or col>=H_ACTIVE as invalid: no line-buffer write, no window shift, o_valid=0 for it.
REQ-015 SHALL compute luma Y = (77*R + 150*G + 29*B) >> 8 in a 16-bit intermediate; Y is 8-bit, max 255.
REQ-016 SHALL hold two line buffers of H_ACTIVE x 8 bits, indexed by col, written only on valid pixels; read-before-write at the same address.
REQ-017 SHALL keep a 3x3 window register of Y, shifted one column per valid pixel; window cleared when col==0.
REQ-018 SHALL compute signed Gx, Gy (11-bit) with standard Sobel kernels, magnitude M = |Gx| + |Gy| (12-bit), saturated to 255.
REQ-019 SHALL, for input at (row, col), centre the window at (row-1, col-1); the edge image is thereby shifted by one pixel right and down relative to o_row/o_col.
REQ-020 SHALL, when edge_enable=1, drive all three channels 8'hFF if M > threshold, else 8'h00; strictly greater-than.
REQ-021 SHALL, when edge_enable=0, drive o_VGA_* = i_VGA_* delayed exactly LATENCY cycles.
REQ-022 SHALL pipeline edge_enable with the pixel, so a mode change is pixel-aligned; threshold is sampled in the final stage.
REQ-023 SHALL run a frame FSM: IDLE (after reset, wait for SOF), FILL (rows 0-1), RUN (rows >= 2); SOF = valid pixel at row==0, col==0.
REQ-024 SHALL transition IDLE->FILL on SOF, FILL->RUN on the first valid pixel with row==2, and any state->FILL on SOF (mid-frame restart).
REQ-025 SHALL force edge output 8'h00 unless the state is RUN and col>=2; passthrough mode is unaffected by state.
REQ-026 SHALL keep o_valid/o_row/o_col timing independent of pix_valid gaps: the pipeline is free-running, and blanking produces o_valid=0 slots.

Reset
REQ-027 SHALL on rst_n=0 asynchronously clear o_VGA_*, o_row, o_col, o_valid, all pipeline and window registers to 0, and set FSM to IDLE.
REQ-028 SHALL NOT reset line-buffer RAM contents; FILL gating makes stale data unobservable.
REQ-029 SHALL on reset release mid-frame output black in edge mode until the next SOF plus two lines.

Structure
REQ-030 SHALL place H_ACTIVE/V_ACTIVE defaults, luma coefficients, and FSM state encoding in shared package vid_pkg.
REQ-031 SHALL implement each line buffer as sub-module line_buffer (single-port read-before-write, inferable M10K), instantiated twice.

Verification
REQ-032 SHALL verify reset: rst_n=0 mid-stream -> all outputs 0 within the same cycle, o_valid=0.
REQ-033 SHALL verify passthrough: edge_enable=0, pixel (0x12,0x34,0x56) at cycle t -> identical pixel, o_valid=1, same row/col at t+4.
REQ-034 SHALL verify a flat frame: all pixels 0x80, edge_enable=1, threshold=0x10 -> every output 0x00.
REQ-035 SHALL verify a vertical step: cols<320 = 0x00, cols>=320 = 0xFF, threshold=0x40 -> 0xFF only at o_col 320 and 321 for o_row>=2; 0x00 elsewhere.
REQ-036 SHALL verify borders: the step image of REQ-035 -> o_row 0-1 and o_col 0-1 all 0x00.
REQ-037 SHALL verify mid-frame recovery: SOF injected at row 100 -> rows 0-1 of the new frame black, edges valid from row 2.
